// File: rtl/hand_image_stream_gen.sv
// Synthetic hand-sign raster source: a palm rectangle plus one finger rectangle above it,
// streamed row-major as a 1-bit object_image with de_t, with line/frame blanking and pause.
module hand_image_stream_gen #(
  parameter int unsigned IMG_WIDTH  = 120,
  parameter int unsigned IMG_HEIGHT = 160,
  parameter int unsigned HBLANK     = 4,
  parameter int unsigned VBLANK     = 8,
  parameter int unsigned CW         = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          cont,
  input  logic          pause,
  input  logic [CW-1:0] palm_r0,
  input  logic [CW-1:0] palm_c0,
  input  logic [CW-1:0] palm_w,
  input  logic [CW-1:0] palm_h,
  input  logic [CW-1:0] fing_c0,
  input  logic [CW-1:0] fing_w,
  input  logic [CW-1:0] fing_h,
  output logic          de_t,
  output logic          object_image,
  output logic [CW-1:0] row,
  output logic [CW-1:0] col,
  output logic          sof,
  output logic          frame_done,
  output logic          busy
);

  localparam int unsigned BMAX = (HBLANK > VBLANK) ? HBLANK : VBLANK;
  localparam int unsigned BW   = $clog2(BMAX + 2);
  localparam logic [CW-1:0] LAST_COL = CW'(IMG_WIDTH - 1);
  localparam logic [CW-1:0] LAST_ROW = CW'(IMG_HEIGHT - 1);

  typedef enum logic [2:0] {IDLE, ACTIVE, HBL, VBL, DONE} state_t;

  typedef struct packed {
    logic [CW-1:0] palm_r0;
    logic [CW-1:0] palm_c0;
    logic [CW-1:0] palm_w;
    logic [CW-1:0] palm_h;
    logic [CW-1:0] fing_c0;
    logic [CW-1:0] fing_w;
    logic [CW-1:0] fing_h;
  } geom_t;

  state_t        state;
  logic [BW-1:0] bcnt;
  geom_t         shadow;
  geom_t         geom_in_c;
  geom_t         geom_c;
  logic          emit_c;
  logic          emit_pix_c;
  logic [CW-1:0] emit_row_c;
  logic [CW-1:0] emit_col_c;

  assign geom_in_c = {palm_r0, palm_c0, palm_w, palm_h, fing_c0, fing_w, fing_h};

  // Hand membership test, widened by one bit so region ends and the finger top never wrap.
  function automatic logic in_hand(input logic [CW-1:0] r, input logic [CW-1:0] c,
                                   input geom_t g);
    logic [CW:0] re, ce, p_r0, p_rend, p_c0, p_cend, f_c0, f_cend, f_h;
    logic        palm, fing;
    re     = (CW+1)'(r);
    ce     = (CW+1)'(c);
    p_r0   = (CW+1)'(g.palm_r0);
    p_rend = (CW+1)'(g.palm_r0) + (CW+1)'(g.palm_h);
    p_c0   = (CW+1)'(g.palm_c0);
    p_cend = (CW+1)'(g.palm_c0) + (CW+1)'(g.palm_w);
    f_c0   = (CW+1)'(g.fing_c0);
    f_cend = (CW+1)'(g.fing_c0) + (CW+1)'(g.fing_w);
    f_h    = (CW+1)'(g.fing_h);
    palm   = (re >= p_r0) && (re < p_rend) && (ce >= p_c0) && (ce < p_cend);
    fing   = (re < p_r0) && ((re + f_h) >= p_r0) && (ce >= f_c0) && (ce < f_cend);
    return palm || fing;
  endfunction

  // Position and value of the pixel that the next clock edge would present.
  always_comb begin
    geom_c     = shadow;
    emit_c     = 1'b0;
    emit_row_c = '0;
    emit_col_c = '0;
    case (state)
      IDLE: begin
        geom_c = geom_in_c;
        emit_c = start;
      end
      ACTIVE: begin
        emit_c = !pause && ((col != LAST_COL) || (HBLANK == 0 && row != LAST_ROW));
        if (col == LAST_COL) begin
          emit_row_c = row + CW'(1);
        end else begin
          emit_row_c = row;
          emit_col_c = col + CW'(1);
        end
      end
      HBL: begin
        emit_c     = (bcnt == BW'(HBLANK)) && (row != LAST_ROW);
        emit_row_c = row + CW'(1);
      end
      DONE: begin
        geom_c = geom_in_c;
        emit_c = cont;
      end
      default: ;
    endcase
    emit_pix_c = in_hand(emit_row_c, emit_col_c, geom_c);
  end

  // Frame sequencer with registered pixel outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      bcnt         <= '0;
      shadow       <= '0;
      de_t         <= 1'b0;
      object_image <= 1'b0;
      row          <= '0;
      col          <= '0;
      sof          <= 1'b0;
      frame_done   <= 1'b0;
      busy         <= 1'b0;
    end else begin
      de_t         <= 1'b0;
      object_image <= 1'b0;
      sof          <= 1'b0;
      frame_done   <= 1'b0;
      if (emit_c) begin
        de_t         <= 1'b1;
        object_image <= emit_pix_c;
        row          <= emit_row_c;
        col          <= emit_col_c;
        sof          <= (state == IDLE) || (state == DONE);
      end
      case (state)
        IDLE: begin
          if (start) begin
            shadow <= geom_in_c;
            busy   <= 1'b1;
            state  <= ACTIVE;
          end
        end
        ACTIVE: begin
          if (!pause && col == LAST_COL) begin
            if (HBLANK != 0) begin
              state <= HBL;
              bcnt  <= BW'(1);
            end else if (row == LAST_ROW) begin
              if (VBLANK != 0) begin
                state <= VBL;
                bcnt  <= BW'(1);
              end else begin
                state      <= DONE;
                frame_done <= 1'b1;
              end
            end
          end
        end
        HBL: begin
          if (bcnt != BW'(HBLANK)) begin
            bcnt <= bcnt + BW'(1);
          end else if (row != LAST_ROW) begin
            state <= ACTIVE;
          end else if (VBLANK != 0) begin
            state <= VBL;
            bcnt  <= BW'(1);
          end else begin
            state      <= DONE;
            frame_done <= 1'b1;
          end
        end
        VBL: begin
          if (bcnt != BW'(VBLANK)) begin
            bcnt <= bcnt + BW'(1);
          end else begin
            state      <= DONE;
            frame_done <= 1'b1;
          end
        end
        DONE: begin
          if (cont) begin
            shadow <= geom_in_c;
            state  <= ACTIVE;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hand_image_stream_gen.sv
// Scoreboard bench for hand_image_stream_gen: expected pixel streams and frame lengths are
// queued from a rectangle-arithmetic model; a monitor pops and compares on every de_t.
module tb_hand_image_stream_gen;

  localparam int W  = 120;
  localparam int H  = 160;
  localparam int HB = 4;
  localparam int VB = 8;
  localparam int CW = 10;
  localparam int FRAME_LEN = H * (W + HB) + VB;

  typedef struct {
    int pr0; int pc0; int pw; int ph; int fc0; int fw; int fh;
  } geom_t;

  typedef struct {
    int row; int col; int pix; int sof;
  } pix_t;

  logic          clk, rst, start, cont, pause;
  logic [CW-1:0] palm_r0, palm_c0, palm_w, palm_h, fing_c0, fing_w, fing_h;
  logic          de_t, object_image, sof, frame_done, busy;
  logic [CW-1:0] row, col;

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   sof_cyc = 0;
  int   de_cnt = 0;
  int   ones_cnt = 0;
  int   fd_count = 0;
  pix_t exp_q[$];
  int   len_q[$];

  hand_image_stream_gen #(
    .IMG_WIDTH(W), .IMG_HEIGHT(H), .HBLANK(HB), .VBLANK(VB), .CW(CW)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .cont(cont), .pause(pause),
    .palm_r0(palm_r0), .palm_c0(palm_c0), .palm_w(palm_w), .palm_h(palm_h),
    .fing_c0(fing_c0), .fing_w(fing_w), .fing_h(fing_h),
    .de_t(de_t), .object_image(object_image), .row(row), .col(col),
    .sof(sof), .frame_done(frame_done), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // A pixel is hand iff it falls in the palm box or in the finger box stacked above it.
  function automatic int model_pix(input int r, input int c, input geom_t g);
    bit palm, fing;
    palm = (r >= g.pr0) && (r <= g.pr0 + g.ph - 1) && (c >= g.pc0) && (c <= g.pc0 + g.pw - 1);
    fing = (r >= g.pr0 - g.fh) && (r <= g.pr0 - 1) && (c >= g.fc0) && (c <= g.fc0 + g.fw - 1);
    return (palm || fing) ? 1 : 0;
  endfunction

  task automatic push_frame(input geom_t g, output int ones);
    pix_t e;
    ones = 0;
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        e.row = r; e.col = c; e.pix = model_pix(r, c, g); e.sof = (r == 0 && c == 0) ? 1 : 0;
        exp_q.push_back(e);
        ones += e.pix;
      end
    end
    len_q.push_back(FRAME_LEN);
  endtask

  task automatic apply_geom(input geom_t g);
    palm_r0 = CW'(g.pr0); palm_c0 = CW'(g.pc0); palm_w = CW'(g.pw); palm_h = CW'(g.ph);
    fing_c0 = CW'(g.fc0); fing_w = CW'(g.fw); fing_h = CW'(g.fh);
  endtask

  function automatic geom_t rand_geom();
    geom_t g;
    g.pr0 = int'($urandom_range(0, 170)); g.pc0 = int'($urandom_range(0, 130));
    g.pw  = int'($urandom_range(0, 60));  g.ph  = int'($urandom_range(0, 60));
    g.fc0 = int'($urandom_range(0, 130)); g.fw  = int'($urandom_range(0, 20));
    g.fh  = int'($urandom_range(0, 40));
    return g;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_pixel(input int r, input int c, input int max_cyc);
    int n;
    n = 0;
    while (!(de_t && int'(row) == r && int'(col) == c) && n < max_cyc) begin
      tick();
      n++;
    end
    if (n >= max_cyc) chk("wait_pixel_timeout", 0, 1);
  endtask

  task automatic wait_fd(input int max_cyc);
    int n;
    n = 0;
    while (!frame_done && n < max_cyc) begin
      tick();
      n++;
    end
    if (n >= max_cyc) chk("frame_done_timeout", 0, 1);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_de_t"}, int'(de_t), 0);
    chk({tag, "_object_image"}, int'(object_image), 0);
    chk({tag, "_row"}, int'(row), 0);
    chk({tag, "_col"}, int'(col), 0);
    chk({tag, "_sof"}, int'(sof), 0);
    chk({tag, "_frame_done"}, int'(frame_done), 0);
    chk({tag, "_busy"}, int'(busy), 0);
  endtask

  // Monitor: pixel scoreboard, blanking sanity, frame length and frame statistics.
  always @(negedge clk) begin
    pix_t e;
    if (!rst) begin
      if (de_t) begin
        if (sof) begin
          sof_cyc  = cyc;
          de_cnt   = 0;
          ones_cnt = 0;
        end
        de_cnt++;
        ones_cnt += int'(object_image);
        if (exp_q.size() == 0) begin
          chk("unexpected_pixel", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("pix_row", int'(row), e.row);
          chk("pix_col", int'(col), e.col);
          chk("pix_object_image", int'(object_image), e.pix);
          chk("pix_sof", int'(sof), e.sof);
        end
      end else begin
        chk("blank_object_image", int'(object_image), 0);
        chk("blank_sof", int'(sof), 0);
      end
      if (frame_done) begin
        fd_count++;
        chk("frame_done_busy", int'(busy), 1);
        if (len_q.size() == 0) chk("unexpected_frame_done", 1, 0);
        else chk("frame_length", cyc - sof_cyc, len_q.pop_front());
      end
    end
  end

  initial begin
    geom_t gA, gB, gC, gD;
    int    onesA, onesB, onesC, onesD, onesE, fd_before, k;
    rst = 1'b1; start = 1'b0; cont = 1'b0; pause = 1'b0;
    gA = '{pr0: 100, pc0: 40, pw: 30, ph: 40, fc0: 50, fw: 5, fh: 20};
    apply_geom(gA);
    repeat (3) tick();
    chk_all_zero("reset");
    rst = 1'b0;
    tick();

    // Frame A: nominal shape, ignored restart and geometry change, 7-cycle pause at (3,10).
    push_frame(gA, onesA);
    len_q[$] = len_q[$] + 7;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("a_first_sof", int'(sof), 1);
    chk("a_first_de_t", int'(de_t), 1);
    chk("a_busy", int'(busy), 1);
    wait_pixel(1, 5, 500);
    start = 1'b1;
    palm_w = CW'(50);
    tick();
    start = 1'b0;
    wait_pixel(3, 10, 500);
    pause = 1'b1;
    for (int i = 0; i < 7; i++) begin
      tick();
      chk("pause_de_t", int'(de_t), 0);
      chk("pause_row", int'(row), 3);
      chk("pause_col", int'(col), 10);
    end
    pause = 1'b0;
    tick();
    chk("resume_col", int'(col), 11);
    wait_fd(25000);
    chk("a_de_count", de_cnt, 19200);
    chk("a_ones", ones_cnt, 1300);
    chk("a_ones_model", onesA, ones_cnt);
    tick();
    chk("a_busy_after", int'(busy), 0);
    chk("a_fd_pulse", int'(frame_done), 0);

    // Frames B/C: clipped shape in continuous mode, random geometry taken at B's frame_done.
    gB = '{pr0: 5, pc0: 110, pw: 30, ph: 40, fc0: 50, fw: 5, fh: 20};
    apply_geom(gB);
    push_frame(gB, onesB);
    cont = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("b_sof", int'(sof), 1);
    wait_pixel(100, 0, 15000);
    gC = rand_geom();
    apply_geom(gC);
    push_frame(gC, onesC);
    wait_fd(25000);
    chk("b_de_count", de_cnt, 19200);
    chk("b_ones", ones_cnt, 425);
    tick();
    chk("c_cont_sof", int'(sof), 1);
    chk("c_cont_busy", int'(busy), 1);
    cont = 1'b0;
    k = 0;
    while (!frame_done && k < 30000) begin
      if (de_t && $urandom_range(0, 31) == 0) begin
        pause = 1'b1;
        for (int p = int'($urandom_range(1, 5)); p > 0; p--) begin
          if (len_q.size() > 0) len_q[$] = len_q[$] + 1;
          tick();
          k++;
        end
        pause = 1'b0;
      end
      tick();
      k++;
    end
    if (k >= 30000) chk("c_frame_done_timeout", 0, 1);
    chk("c_de_count", de_cnt, 19200);
    chk("c_ones", ones_cnt, onesC);
    tick();
    chk("c_busy_after", int'(busy), 0);
    chk("c_queue_empty", exp_q.size(), 0);

    // Frame D: reset at row 60 aborts without frame_done.
    gD = rand_geom();
    apply_geom(gD);
    push_frame(gD, onesD);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_pixel(60, 0, 10000);
    fd_before = fd_count;
    rst = 1'b1;
    tick();
    exp_q.delete();
    len_q.delete();
    chk_all_zero("midreset");
    rst = 1'b0;
    repeat (5) tick();
    chk("midreset_no_fd", fd_count, fd_before);
    chk("midreset_idle_de_t", int'(de_t), 0);

    // Frame E: restart after reset, checked for a few rows and then aborted.
    apply_geom(gA);
    push_frame(gA, onesE);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("e_sof", int'(sof), 1);
    chk("e_row", int'(row), 0);
    chk("e_col", int'(col), 0);
    repeat (400) tick();
    rst = 1'b1;
    tick();
    exp_q.delete();
    len_q.delete();
    rst = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
